// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-bridge arbiter.
// Holds the read/write size encodings, the line geometry, the owner
// encoding and the read FSM state encoding.
package cache_pkg;

    // Request size encodings (rd_type / wr_type)
    localparam logic [2:0] TYPE_B    = 3'd0;
    localparam logic [2:0] TYPE_H    = 3'd1;
    localparam logic [2:0] TYPE_W    = 3'd2;
    localparam logic [2:0] TYPE_D    = 3'd3;
    localparam logic [2:0] TYPE_LINE = 3'd4;

    // Line geometry: addr[31:LINE_OFF] is the line address, and a line
    // read returns LINE_BEATS 64-bit beats.
    localparam int LINE_OFF   = 4;
    localparam int LINE_BEATS = 2;

    // Read owner
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : arbitration allowed this cycle (last owner only moves when set)
//   req_i    : [0] icache, [1] dcache
//   gnt_o    : one-hot grant, combinational, zero when en_i is low
// On a tie the requester that did not win last time is granted.
module rr_arb2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&req_i) gnt_o = (last_q == OWN_I) ? 2'b10 : 2'b01;
            else        gnt_o = req_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                     last_q <= OWN_I;
        else if (en_i && |req_i)     last_q <= gnt_o[1] ? OWN_D : OWN_I;
    end

endmodule

// File: rtl/cache_axi_arb.sv
// Shares one downstream bridge port between the icache (reads) and the
// dcache (reads and writes).
//   i_rd_* / d_rd_* : cache read request/response channels
//   d_wr_*          : dcache write request channel
//   m_rd_* / m_wr_* : downstream bridge port
//   prot_err        : sticky, rlast seen on the wrong beat or rvalid with
//                     no read in its data phase
// Reads are serialised (one outstanding) with round-robin ownership held
// until the last beat. Writes pass straight through, one outstanding; a
// pending write blocks dcache reads to its line and all uncached dcache
// reads until its response arrives.
module cache_axi_arb
    import cache_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]        i_rd_type,
    output logic              i_rd_ready,
    output logic [63:0]       i_rdata,
    output logic              i_rvalid,
    output logic              i_rlast,
    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    input  logic [2:0]        d_rd_type,
    output logic              d_rd_ready,
    output logic [63:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_rlast,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [127:0]      d_wdata,
    input  logic [2:0]        d_wr_type,
    input  logic [7:0]        d_wstrb,
    output logic              d_wr_ready,
    output logic              m_rd_req,
    output logic [ADDR_W-1:0] m_rd_addr,
    output logic [2:0]        m_rd_type,
    input  logic              m_rd_ready,
    input  logic [63:0]       m_rdata,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    output logic              m_wr_req,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [127:0]      m_wdata,
    output logic [2:0]        m_wr_type,
    output logic [7:0]        m_wstrb,
    input  logic              m_wr_ready,
    input  logic              m_wr_done,
    output logic              prot_err
);

    localparam int LW = 32 - LINE_OFF;
    localparam int CW = $clog2(LINE_BEATS) + 1;

    rd_state_e         state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [CW-1:0]     beat_q;
    logic              perr_q;
    logic              m_rd_req_q;
    logic              wr_pend_q;
    logic [LW-1:0]     wr_line_q;

    logic              wr_fire;
    logic              pend_now;
    logic [LW-1:0]     line_now;
    logic              d_blk;
    logic [1:0]        gnt;
    logic [CW-1:0]     last_beat;

    assign wr_fire = d_wr_req && !wr_pend_q && m_wr_ready;

    // A write accepted this very cycle already counts as pending, so a
    // same-line read presented alongside it cannot slip past.
    assign pend_now = wr_pend_q || wr_fire;
    assign line_now = wr_pend_q ? wr_line_q : d_wr_addr[31:LINE_OFF];
    assign d_blk    = pend_now && ((d_rd_type != TYPE_LINE) ||
                                   (d_rd_addr[31:LINE_OFF] == line_now));

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == R_IDLE),
        .req_i ({d_rd_req && !d_blk, i_rd_req}),
        .gnt_o (gnt)
    );

    assign last_beat = (type_q == TYPE_LINE) ? CW'(LINE_BEATS - 1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= R_IDLE;
            owner_q    <= OWN_I;
            addr_q     <= '0;
            type_q     <= '0;
            beat_q     <= '0;
            perr_q     <= 1'b0;
            m_rd_req_q <= 1'b0;
        end else begin
            if (m_rvalid && state_q != R_DATA) perr_q <= 1'b1;
            case (state_q)
                R_IDLE: if (|gnt) begin
                    owner_q    <= gnt[1] ? OWN_D : OWN_I;
                    addr_q     <= gnt[1] ? d_rd_addr : i_rd_addr;
                    type_q     <= gnt[1] ? d_rd_type : i_rd_type;
                    m_rd_req_q <= 1'b1;
                    state_q    <= R_REQ;
                end
                R_REQ: if (m_rd_ready) begin
                    m_rd_req_q <= 1'b0;
                    beat_q     <= '0;
                    state_q    <= R_DATA;
                end
                R_DATA: if (m_rvalid) begin
                    beat_q <= beat_q + CW'(1);
                    if (m_rlast) begin
                        if (beat_q != last_beat) perr_q <= 1'b1;
                        state_q <= R_IDLE;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            wr_line_q <= '0;
        end else if (wr_fire) begin
            wr_pend_q <= 1'b1;
            wr_line_q <= d_wr_addr[31:LINE_OFF];
        end else if (m_wr_done) begin
            wr_pend_q <= 1'b0;
        end
    end

    // Every output is forced low while rst is held.
    always_comb begin
        i_rd_ready = 1'b0;  i_rdata = '0;  i_rvalid = 1'b0;  i_rlast = 1'b0;
        d_rd_ready = 1'b0;  d_rdata = '0;  d_rvalid = 1'b0;  d_rlast = 1'b0;
        m_rd_req   = 1'b0;  m_rd_addr = '0;  m_rd_type = '0;
        m_wr_req   = 1'b0;  m_wr_addr = '0;  m_wdata = '0;
        m_wr_type  = '0;    m_wstrb = '0;    d_wr_ready = 1'b0;
        prot_err   = 1'b0;
        if (!rst) begin
            m_rd_req   = m_rd_req_q;
            m_rd_addr  = m_rd_req_q ? addr_q : '0;
            m_rd_type  = m_rd_req_q ? type_q : '0;
            i_rd_ready = m_rd_req_q && (owner_q == OWN_I) && m_rd_ready;
            d_rd_ready = m_rd_req_q && (owner_q == OWN_D) && m_rd_ready;
            if (state_q == R_DATA) begin
                if (owner_q == OWN_I) begin
                    i_rdata = m_rdata;  i_rvalid = m_rvalid;  i_rlast = m_rlast;
                end else begin
                    d_rdata = m_rdata;  d_rvalid = m_rvalid;  d_rlast = m_rlast;
                end
            end
            m_wr_req   = d_wr_req && !wr_pend_q;
            d_wr_ready = m_wr_ready && !wr_pend_q;
            m_wr_addr  = d_wr_addr;
            m_wdata    = d_wdata;
            m_wr_type  = d_wr_type;
            m_wstrb    = d_wstrb;
            prot_err   = perr_q;
        end
    end

endmodule
